// File: rtl/serializer_pkg.sv
// Shared types and defaults for the bit serializer.
// The serializer's optional one-cycle GAP between words is enabled by defining SERIALIZER_GAP_EN.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_e;

endpackage

// File: rtl/ser_bit_cnt.sv
// Bit position counter for the serializer.
// It saturates at WIDTH-1 and raises last_c while it holds that value.
module ser_bit_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  output logic [$clog2(WIDTH)-1:0]   count,
  output logic                       last_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  assign last_c = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !last_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the downstream sequence detector's X input.
// Defining SERIALIZER_GAP_EN inserts one idle GAP cycle after every word.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             X,
  output logic             x_valid,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
`ifdef SERIALIZER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             x_d, xv_d, busy_d, ready_d;
  logic             load, cnt_clr, cnt_en, last_c, accept_c;
  logic [CNT_W-1:0] cnt;

  // The bit currently on X always sits at the pick position of sh_q.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  function automatic logic pick_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  assign accept_c = din_valid && din_ready;

  ser_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (cnt),
    .last_c (last_c)
  );

  // State and output registers; reset has priority over any accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      X         <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      X         <= x_d;
      x_valid   <= xv_d;
      busy      <= busy_d;
      din_ready <= ready_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    busy_d  = 1'b0;
    ready_d = 1'b0;
    load    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          load = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end

      SHIFT: begin
        if (!last_c) begin
          cnt_en  = 1'b1;
          sh_d    = shift_word(sh_q);
          x_d     = pick_bit(sh_d);
          xv_d    = 1'b1;
          busy_d  = 1'b1;
          // Ready rises together with the final bit so a new word can stream in.
          ready_d = !GAP_EN && (cnt == CNT_W'(WIDTH - 2));
        end else if (GAP_EN) begin
          state_d = GAP;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end else if (accept_c) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end

      GAP: begin
        if (accept_c) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (load) begin
      state_d = SHIFT;
      sh_d    = din;
      x_d     = pick_bit(din);
      xv_d    = 1'b1;
      busy_d  = 1'b1;
      ready_d = 1'b0;
      cnt_clr = 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: MSB-first and LSB-first instances share stimulus,
// a word-level model checks every cycle, and a small Moore detector consumes the MSB stream.
module tb_bit_serializer;
  import serializer_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;
`ifdef SERIALIZER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic x_m, xv_m, busy_m, rdy_m;
  logic x_l, xv_l, busy_l, rdy_l;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .X(x_m), .x_valid(xv_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .X(x_l), .x_valid(xv_l), .busy(busy_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: index 0 is MSB-first, index 1 is LSB-first.
  logic [W-1:0] m_word[2];
  int           m_left[2];   // payload bits still to show, including the current one
  bit           m_gap[2];
  bit           m_acc[2];
  bit           m_rdy[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 1'b0;
      if (!rst) begin
        m_left[k] = 0;
        m_gap[k]  = 1'b0;
      end else if (din_valid && m_rdy[k]) begin
        m_word[k] = din;
        m_left[k] = W;
        m_gap[k]  = 1'b0;
        m_acc[k]  = 1'b1;
      end else if (m_left[k] > 1) begin
        m_left[k] = m_left[k] - 1;
      end else if (m_left[k] == 1) begin
        m_left[k] = 0;
        m_gap[k]  = GAP_EN;
      end else begin
        m_gap[k] = 1'b0;
      end
      m_rdy[k] = (m_left[k] == 0) || (!GAP_EN && m_left[k] == 1);
    end
  end

  function automatic logic exp_x(input int k);
    int idx;
    if (m_left[k] == 0) return 1'b0;
    idx = (k == 0) ? m_left[k] - 1 : int'(W) - m_left[k];
    return m_word[k][idx];
  endfunction

  // Downstream Moore detector for 1011 (overlapping), fed by the MSB-first stream.
  logic [3:0] hist;
  int         dcnt;
  logic       y;
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
      dcnt <= 0;
    end else if (xv_m) begin
      hist <= {hist[2:0], x_m};
      dcnt <= dcnt + 1;
    end
  end
  assign y = (hist == 4'b1011);

  function automatic logic [15:0] ref_hits(input logic [15:0] s);
    logic [15:0] h = '0;
    logic [3:0]  win;
    for (int k = 3; k < 16; k++) begin
      win  = {s[15-(k-3)], s[15-(k-2)], s[15-(k-1)], s[15-k]};
      h[k] = (win == 4'b1011);
    end
    return h;
  endfunction

  // Per-cycle compare against the model plus cumulative recorders.
  bit          chk_en = 1'b0;
  logic [7:0]  seen_m = '0, seen_l = '0;
  int          nv_m = 0, nv_l = 0, cyc = 0;
  bit          xv_trace[1024];
  logic [15:0] y_log = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("m.X",         x_m,    exp_x(0));
      check("m.x_valid",   xv_m,   m_left[0] > 0);
      check("m.busy",      busy_m, (m_left[0] > 0) || m_gap[0]);
      check("m.din_ready", rdy_m,  m_rdy[0]);
      check("l.X",         x_l,    exp_x(1));
      check("l.x_valid",   xv_l,   m_left[1] > 0);
      check("l.busy",      busy_l, (m_left[1] > 0) || m_gap[1]);
      check("l.din_ready", rdy_l,  m_rdy[1]);
    end
    if (xv_m) begin seen_m = {seen_m[6:0], x_m}; nv_m++; end
    if (xv_l) begin seen_l = {seen_l[6:0], x_l}; nv_l++; end
    if (dcnt > 0 && dcnt <= 16) y_log[dcnt-1] = y;
    if (cyc < 1024) xv_trace[cyc] = xv_m;
    cyc++;
  end

  task automatic wait_accept(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_acc[0] && t < 50);
    if (!m_acc[0]) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: word not accepted within 50 cycles", name);
    end
  endtask

  task automatic send(input logic [7:0] w);
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    wait_accept("send");
    din_valid = 1'b0;
  endtask

  task automatic stream2(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    din       = a;
    din_valid = 1'b1;
    wait_accept("stream.first");
    din = b;
    wait_accept("stream.second");
    din_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int nv0, nl0, c0, ones, first, last;

    // Reset with din_valid high: the word must not be taken.
    din       = 8'hFF;
    din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst.X", x_m, 1'b0);
    check("rst.x_valid", xv_m, 1'b0);
    check("rst.busy", busy_m, 1'b0);
    check("rst.din_ready", rdy_m, 1'b1);
    check("rst.no_accept", nv_m, 0);

    // Single word, both bit orders.
    nv0 = nv_m; nl0 = nv_l;
    send(8'b1101_1100);
    repeat (10) @(negedge clk);
    @(posedge clk);
    check("w1.seq_msb", seen_m, 8'hDC);
    check("w1.seq_lsb", seen_l, 8'h3B);
    check("w1.count_msb", nv_m - nv0, 8);
    check("w1.count_lsb", nv_l - nl0, 8);

    send(8'h01);
    repeat (10) @(negedge clk);
    @(posedge clk);
    check("w2.seq_msb", seen_m, 8'h01);
    check("w2.seq_lsb", seen_l, 8'h80);

    // Back-to-back words with din_valid held high.
    @(posedge clk);
    c0 = cyc;
    stream2(8'hFF, 8'h00);
    repeat (22) @(negedge clk);
    @(posedge clk);
    ones = 0; first = -1; last = -1;
    for (int i = c0; i < cyc && i < 1024; i++) begin
      if (xv_trace[i]) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("stream.valid_bits", ones, 16);
    check("stream.hole_cycles", last - first + 1 - ones, GAP_EN ? 1 : 0);

    // Reset while bit 4 of 0xAA is on X, with a competing din_valid.
    nv0 = nv_m; nl0 = nv_l;
    send(8'hAA);
    repeat (4) @(negedge clk);
    rst       = 1'b0;
    din       = 8'hFF;
    din_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk);
    check("abort.count_msb", nv_m - nv0, 5);
    check("abort.count_lsb", nv_l - nl0, 5);
    check("abort.bits_msb", seen_m[4:0], 5'b10101);
    check("abort.bits_lsb", seen_l[4:0], 5'b01010);

    // din scrambled while the word is shifting.
    send(8'hC5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      din = 8'($urandom);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    check("hold.seq_msb", seen_m, 8'hC5);
    check("hold.seq_lsb", seen_l, 8'hA3);

    // Detector driven by the serializer.
    pulse_reset();
    @(posedge clk);
    y_log = '0;
    stream2(8'b0110_1110, 8'b1110_0000);
    repeat (22) @(negedge clk);
    @(posedge clk);
    check("det.bits", dcnt, 16);
    check("det.y_literal", y_log, 16'h0220);
    for (int k = 0; k < 16; k++) begin
      logic [15:0] r;
      r = ref_hits({8'b0110_1110, 8'b1110_0000});
      check($sformatf("det.y[%0d]", k), y_log[k], r[k]);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits per parallel word (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset, sampled on the clk rising edge).
REQ-005 The block SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din holds a word offered for transfer.
REQ-007 The block SHALL have port din_ready, output, 1 bit: the block accepts din on this edge if din_valid=1.
REQ-008 The block SHALL have port X, output, 1 bit: serial bit stream feeding the downstream Moore sequence detector's X input.
REQ-009 The block SHALL have port x_valid, output, 1 bit: X carries a payload bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: a word is being shifted out.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT and GAP (GAP is reachable only with the configuration macro).
REQ-012 A word SHALL transfer on a rising edge where din_valid=1 and din_ready=1; din is captured into an internal shift register on that edge.
REQ-013 X, x_valid and busy SHALL be registered outputs; the first bit of an accepted word SHALL appear on X in the cycle immediately following the accept edge (latency 1 cycle).
REQ-014 In SHIFT, exactly one bit SHALL be presented per cycle for WIDTH consecutive cycles with x_valid=1 and busy=1; bit order follows MSB_FIRST.
REQ-015 A bit counter of width clog2(WIDTH) SHALL count 0..WIDTH-1 and reset to 0 on every accept; there is no wrap-around beyond WIDTH-1.
REQ-016 din_ready SHALL be 1 in IDLE and, without the macro, also during the last bit cycle of SHIFT (counter = WIDTH-1); otherwise 0.
REQ-017 If a word is accepted during the last bit cycle, the next word's first bit SHALL follow with no idle cycle (back-to-back streaming).
REQ-018 If din_valid=0 at the end of the last bit, the FSM SHALL enter IDLE with X=0, x_valid=0, busy=0.
REQ-019 In IDLE, X SHALL be driven 0 so the downstream detector sees a neutral input.
REQ-020 din changes while din_ready=0 SHALL have no effect on the word being shifted.

Reset
REQ-021 When rst=0 at a rising edge, the FSM SHALL enter IDLE; the shift register and counter SHALL clear to 0; X=0, x_valid=0, busy=0; din_ready SHALL be 1 in the first cycle after rst returns to 1.
REQ-022 Reset asserted mid-word SHALL abort the word immediately; the remaining bits are discarded and never emitted.
REQ-023 A din_valid asserted in the same cycle as rst=0 SHALL NOT be accepted.

Configuration
REQ-024 The block SHALL use macro SERIALIZER_GAP_EN: when defined, after the last bit the FSM enters GAP for exactly one cycle (X=0, x_valid=0, busy=1); din_ready is 1 in GAP and IDLE but 0 in every SHIFT cycle; when not defined, GAP is absent and REQ-016/REQ-017 apply.

Structure
REQ-025 The package serializer_pkg SHALL hold the FSM state enumeration and the default WIDTH constant.
REQ-026 The bit counter SHALL be one sub-module, ser_bit_cnt, with clear/enable inputs and a last-count flag; everything else stays in bit_serializer.

Verification
REQ-027 The bench SHALL cover: reset, then din=8'b1101_1100 with din_valid=1 for one cycle, MSB_FIRST=1 -> X = 1,1,0,1,1,1,0,0 on 8 consecutive cycles starting one cycle after accept, x_valid=1 throughout, then IDLE.
REQ-028 The bench SHALL cover: MSB_FIRST=0, din=8'h01 -> X = 1 followed by seven 0s.
REQ-029 The bench SHALL cover: din_valid held high with words 8'hFF then 8'h00, macro undefined -> 16 contiguous x_valid cycles, no gap; with SERIALIZER_GAP_EN -> exactly one x_valid=0 cycle between the words.
REQ-030 The bench SHALL cover: rst=0 asserted at bit 4 of 8'hAA -> next cycle X=0, x_valid=0, busy=0; no further bits of 8'hAA emitted.
REQ-031 The bench SHALL cover: din toggled while busy=1 -> the emitted bits match the word captured at accept.
REQ-032 The bench SHALL cover: serializer driving the Moore detector with words 8'b0110_1110 then 8'b1110_0000 -> detector Y matches a reference model of its detection sequence bit-for-bit.
